// File: rtl/hwag_pkg.sv
// Shared widths, register map addresses and arbiter state encoding for the
// hwag configuration register bus.
package hwag_pkg;

  localparam int HWAG_AW        = 8;
  localparam int HWAG_DW        = 16;
  localparam int HWAG_LAST_ADDR = 130;

  localparam int HWATHNB     = 4;
  localparam int HWASTWD     = 5;
  localparam int HWAATOPL    = 6;
  localparam int HWACR0      = 63;
  localparam int HWATHVL     = 70;
  localparam int HWAIGNCHRGL = 127;
  localparam int HWAIGNANGL  = 129;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOOT,
    ST_WR,
    ST_RD,
    ST_RD_CAP,
    ST_ACK
  } arb_state_e;

endpackage

// File: rtl/hwag_cfg_rom.sv
// Default register image: maps each register address to its power-up value.
module hwag_cfg_rom
  import hwag_pkg::*;
#(
  parameter int AW = HWAG_AW,
  parameter int DW = HWAG_DW
) (
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] data_o
);

  always_comb begin
    data_o = '0;
    case (int'(addr_i))
      0:           data_o = DW'(128);
      2:           data_o = DW'(65535);
      HWATHNB:     data_o = DW'(57);
      HWASTWD:     data_o = DW'(4);
      HWAATOPL:    data_o = DW'(3839);
      HWACR0:      data_o = DW'(7);
      65:          data_o = DW'(2);
      HWATHVL:     data_o = DW'(2);
      HWAIGNCHRGL: data_o = DW'(1024);
      HWAIGNANGL:  data_o = DW'(3830);
      default:     data_o = '0;
    endcase
  end

endmodule

// File: rtl/hwag_regbus_arbiter.sv
// Owns the hwag register bus: loads the default image after reset or on
// request, then serves SPI bridge reads and writes. All outputs registered.
module hwag_regbus_arbiter
  import hwag_pkg::*;
#(
  parameter int AW        = HWAG_AW,
  parameter int DW        = HWAG_DW,
  parameter int LAST_ADDR = HWAG_LAST_ADDR,
  parameter bit BOOT_EN   = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          boot_start_i,
  output logic          boot_busy_o,
  output logic          boot_done_o,
  input  logic          spi_req_i,
  input  logic          spi_we_i,
  input  logic [AW-1:0] spi_addr_i,
  input  logic [DW-1:0] spi_wdata_i,
  output logic          spi_ack_o,
  output logic [DW-1:0] spi_rdata_o,
  output logic          spi_err_o,
  output logic [AW-1:0] reg_addr_o,
  output logic [DW-1:0] reg_wdata_o,
  output logic          reg_we_o,
  output logic          reg_re_o,
  input  logic [DW-1:0] reg_rdata_i
);

  localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          boot_busy_q, boot_busy_d;
  logic          boot_done_q, boot_done_d;
  logic          spi_ack_q, spi_ack_d;
  logic          spi_err_q, spi_err_d;
  logic [DW-1:0] spi_rdata_q, spi_rdata_d;
  logic [AW-1:0] reg_addr_q, reg_addr_d;
  logic [DW-1:0] reg_wdata_q, reg_wdata_d;
  logic          reg_we_q, reg_we_d;
  logic          reg_re_q, reg_re_d;

  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          boot_go;
  logic          addr_bad;

  // ROM is addressed with the next boot address so its data lands with the strobe.
  assign rom_addr = (state_q == ST_BOOT) ? cnt_q + AW'(1) : '0;
  assign boot_go  = pend_q | boot_start_i;
  assign addr_bad = spi_addr_i > LAST;

  hwag_cfg_rom #(.AW(AW), .DW(DW)) u_rom (
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q | (boot_start_i & (state_q != ST_BOOT));
    boot_busy_d = boot_busy_q;
    boot_done_d = boot_done_q;
    spi_ack_d   = 1'b0;
    spi_err_d   = 1'b0;
    spi_rdata_d = spi_rdata_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_ACK: begin
        if (boot_go) begin
          state_d     = ST_BOOT;
          cnt_d       = '0;
          pend_d      = 1'b0;
          boot_busy_d = 1'b1;
          boot_done_d = 1'b0;
          reg_we_d    = 1'b1;
          reg_addr_d  = '0;
          reg_wdata_d = rom_data;
        end else if ((state_q == ST_IDLE) && spi_req_i) begin
          if (addr_bad) begin
            state_d   = ST_ACK;
            spi_ack_d = 1'b1;
            spi_err_d = 1'b1;
            if (!spi_we_i) spi_rdata_d = '0;
          end else if (spi_we_i) begin
            state_d     = ST_WR;
            reg_we_d    = 1'b1;
            reg_addr_d  = spi_addr_i;
            reg_wdata_d = spi_wdata_i;
          end else begin
            state_d    = ST_RD;
            reg_re_d   = 1'b1;
            reg_addr_d = spi_addr_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BOOT: begin
        if (cnt_q == LAST) begin
          state_d     = ST_IDLE;
          boot_busy_d = 1'b0;
          boot_done_d = 1'b1;
        end else begin
          cnt_d       = rom_addr;
          reg_we_d    = 1'b1;
          reg_addr_d  = rom_addr;
          reg_wdata_d = rom_data;
        end
      end
      ST_WR: begin
        state_d   = ST_ACK;
        spi_ack_d = 1'b1;
      end
      ST_RD: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        state_d     = ST_ACK;
        spi_ack_d   = 1'b1;
        spi_rdata_d = reg_rdata_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= BOOT_EN;
      boot_busy_q <= 1'b0;
      boot_done_q <= 1'b0;
      spi_ack_q   <= 1'b0;
      spi_err_q   <= 1'b0;
      spi_rdata_q <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      boot_busy_q <= boot_busy_d;
      boot_done_q <= boot_done_d;
      spi_ack_q   <= spi_ack_d;
      spi_err_q   <= spi_err_d;
      spi_rdata_q <= spi_rdata_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
    end
  end

  assign boot_busy_o = boot_busy_q;
  assign boot_done_o = boot_done_q;
  assign spi_ack_o   = spi_ack_q;
  assign spi_err_o   = spi_err_q;
  assign spi_rdata_o = spi_rdata_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_we_o    = reg_we_q;
  assign reg_re_o    = reg_re_q;

endmodule

// File: tb/tb_hwag_regbus_arbiter.sv
// Scoreboard bench for hwag_regbus_arbiter: stimulus queues expected bus
// events with their cycle, a negedge monitor pops and compares them.
module tb_hwag_regbus_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          boot_start = 1'b0;
  logic          boot_busy, boot_done;
  logic          spi_req = 1'b0;
  logic          spi_we = 1'b0;
  logic [AW-1:0] spi_addr = '0;
  logic [DW-1:0] spi_wdata = '0;
  logic          spi_ack, spi_err;
  logic [DW-1:0] spi_rdata;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_we, reg_re;
  logic [DW-1:0] reg_rdata = '0;

  always #5 clk = ~clk;

  hwag_regbus_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .boot_start_i (boot_start),
    .boot_busy_o  (boot_busy),
    .boot_done_o  (boot_done),
    .spi_req_i    (spi_req),
    .spi_we_i     (spi_we),
    .spi_addr_i   (spi_addr),
    .spi_wdata_i  (spi_wdata),
    .spi_ack_o    (spi_ack),
    .spi_rdata_o  (spi_rdata),
    .spi_err_o    (spi_err),
    .reg_addr_o   (reg_addr),
    .reg_wdata_o  (reg_wdata),
    .reg_we_o     (reg_we),
    .reg_re_o     (reg_re),
    .reg_rdata_i  (reg_rdata)
  );

  // kind: 0 = reg write strobe, 1 = reg read strobe, 2 = spi ack
  typedef struct {
    int kind;
    int addr;
    int data;
    int err;
    int chk;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [DW-1:0] mem [256] = '{default: '0};

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: write on strobe, read data one cycle after reg_re.
  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  function automatic int rom_m(input int a);
    case (a)
      0:   return 128;
      2:   return 65535;
      4:   return 57;
      5:   return 4;
      6:   return 3839;
      63:  return 7;
      65:  return 2;
      70:  return 2;
      127: return 1024;
      129: return 3830;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int addr, input int data,
                      input int err, input int chkd, input int c);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    e.err = err; e.chk = chkd; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic push_boot(input int b0, input int n);
    for (int i = 0; i < n; i++) push(0, i, rom_m(i), 0, 0, b0 + i);
  endtask

  task automatic check_evt(input int kind, input int addr, input int data, input int err);
    exp_t e;
    bit ok;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL bus_event: got kind=%0d addr=%0d data=%0d err=%0d cyc=%0d, required no event",
               kind, addr, data, err, cyc);
      return;
    end
    e = q.pop_front();
    if (kind == 2)
      ok = (kind == e.kind) && (cyc == e.cyc) && (err == e.err) && (e.chk == 0 || data == e.data);
    else
      ok = (kind == e.kind) && (cyc == e.cyc) && (addr == e.addr) && (kind == 1 || data == e.data);
    if (!ok) begin
      errors++;
      $display("FAIL bus_event: got kind=%0d addr=%0d data=%0d err=%0d cyc=%0d, required kind=%0d addr=%0d data=%0d err=%0d cyc=%0d",
               kind, addr, data, err, cyc, e.kind, e.addr, e.data, e.err, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reg_we && reg_re) chk("strobe_overlap", 1, 0);
    if (reg_we) check_evt(0, int'(reg_addr), int'(reg_wdata), 0);
    if (reg_re) check_evt(1, int'(reg_addr), 0, 0);
    if (spi_ack) begin
      $display("spi ack: cycle=%0d rdata=%0d err=%0d", cyc, spi_rdata, spi_err);
      check_evt(2, 0, int'(spi_rdata), int'(spi_err));
    end
  end

  task automatic wait_ack(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (spi_ack) begin
        spi_req = 1'b0;
        return;
      end
    end
    spi_req = 1'b0;
    chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) return;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Issue one SPI transaction from IDLE; acceptance edge k = next posedge.
  task automatic spi_txn(input logic we, input int addr, input int wd,
                         input int exp_rd, input int exp_err);
    int k;
    @(negedge clk);
    k = cyc + 1;
    if (exp_err != 0) begin
      push(2, addr, exp_rd, 1, we ? 0 : 1, k);
    end else if (we) begin
      push(0, addr, wd, 0, 0, k);
      push(2, addr, 0, 0, 0, k + 1);
    end else begin
      push(1, addr, 0, 0, 0, k);
      push(2, addr, exp_rd, 0, 1, k + 2);
    end
    spi_we    = we;
    spi_addr  = AW'(addr);
    spi_wdata = DW'(wd);
    spi_req   = 1'b1;
    wait_ack(20);
  endtask

  initial begin
    int b0;
    int k;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_reg_we", int'(reg_we), 0);
    chk("rst_boot_busy", int'(boot_busy), 0);
    chk("rst_boot_done", int'(boot_done), 0);
    chk("rst_spi_ack", int'(spi_ack), 0);
    chk("rst_reg_addr", int'(reg_addr), 0);

    // Automatic boot after reset release
    rst = 1'b0;
    b0 = cyc + 1;
    push_boot(b0, 131);
    @(negedge clk);
    chk("boot_busy_high", int'(boot_busy), 1);
    chk("boot_done_low", int'(boot_done), 0);
    wait_drain(400);
    @(negedge clk);
    chk("boot1_done", int'(boot_done), 1);
    chk("boot1_busy", int'(boot_busy), 0);

    // SPI write / reads / out-of-range accesses
    spi_txn(1'b1, 70, 5, 0, 0);
    spi_txn(1'b0, 6, 0, 3839, 0);
    spi_txn(1'b0, 70, 0, 5, 0);
    spi_txn(1'b0, 129, 0, 3830, 0);
    spi_txn(1'b0, 200, 0, 0, 1);
    spi_txn(1'b1, 131, 16'h77, 0, 1);
    spi_txn(1'b0, 130, 0, 0, 0);

    // Boot on request, aborted by reset after 20 writes
    @(negedge clk);
    boot_start = 1'b1;
    b0 = cyc + 1;
    push_boot(b0, 20);
    @(negedge clk);
    boot_start = 1'b0;
    chk("boot2_done_cleared", int'(boot_done), 0);
    chk("boot2_busy", int'(boot_busy), 1);
    wait_drain(100);
    rst = 1'b1;
    #1;
    chk("abort_reg_we", int'(reg_we), 0);
    chk("abort_boot_busy", int'(boot_busy), 0);
    chk("abort_reg_addr", int'(reg_addr), 0);
    chk("abort_reg_wdata", int'(reg_wdata), 0);
    @(negedge clk);
    @(negedge clk);

    // Restarted boot; SPI write stalls from boot cycle 10, boot_start ignored mid-boot
    rst = 1'b0;
    b0 = cyc + 1;
    push_boot(b0, 131);
    wait_cyc(b0 + 10);
    push(0, 127, 16'h1234, 0, 0, b0 + 132);
    push(2, 127, 0, 0, 0, b0 + 133);
    spi_we    = 1'b1;
    spi_addr  = 8'd127;
    spi_wdata = 16'h1234;
    spi_req   = 1'b1;
    wait_cyc(b0 + 50);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    wait_ack(300);
    chk("boot3_done", int'(boot_done), 1);
    repeat (5) @(negedge clk);
    spi_txn(1'b0, 127, 0, 16'h1234, 0);

    // boot_start during an SPI read: read acks first, boot follows
    @(negedge clk);
    k = cyc + 1;
    push(1, 70, 0, 0, 0, k);
    push(2, 70, 2, 0, 1, k + 2);
    push_boot(k + 3, 131);
    spi_we   = 1'b0;
    spi_addr = 8'd70;
    spi_req  = 1'b1;
    @(negedge clk);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    wait_ack(10);
    wait_drain(300);
    @(negedge clk);
    chk("boot4_done", int'(boot_done), 1);
    chk("boot4_busy", int'(boot_busy), 0);
    spi_txn(1'b0, 127, 0, 1024, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
